// File: rtl/superfx_icache_ctrl.sv
// SuperFX instruction-cache controller: base/range decode, per-line valid bits,
// line-fill and out-of-range bypass state machine, internal byte storage.
module superfx_icache_ctrl #(
  parameter int LINE_BYTES = 16,
  parameter int NUM_LINES  = 32,
  parameter int ADDR_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              fetch_req,
  input  logic              cache_start,
  output logic [7:0]        instr_out,
  output logic              instr_valid,
  output logic              busy,
  output logic              rom_req,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  input  logic              rom_rdy,
  output logic [ADDR_W-1:0] cbr
);

  localparam int LB_W  = $clog2(LINE_BYTES);
  localparam int LN_W  = $clog2(NUM_LINES);
  localparam int IDX_W = LB_W + LN_W;
  localparam int CSIZE = LINE_BYTES * NUM_LINES;

  localparam logic [ADDR_W:0]   CSIZE_X    = (ADDR_W+1)'(CSIZE);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(LINE_BYTES - 1);
  localparam logic [LB_W-1:0]   LAST_BEAT  = LB_W'(LINE_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_BYPASS = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cbr_q, cbr_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [LB_W-1:0]   cnt_q, cnt_d;
  logic [LN_W-1:0]   line_q, line_d;
  logic [LB_W-1:0]   byte_q, byte_d;
  logic [7:0]        instr_q, instr_d;
  logic              rom_req_q, rom_req_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_base_q, pend_base_d;

  logic [7:0]        mem_q [CSIZE];
  logic              mem_we;
  logic [IDX_W-1:0]  mem_widx;

  logic [ADDR_W-1:0] offset;
  logic              in_range;
  logic [LN_W-1:0]   pc_line;
  logic [LB_W-1:0]   pc_byte;
  logic [IDX_W-1:0]  pc_idx;
  logic [ADDR_W-1:0] pc_aligned;
  logic              rdy_acc;

  // Offset wraps modulo 2^ADDR_W, so a window straddling the top of the
  // address space is still contiguous from the cache's point of view.
  assign offset     = pc - cbr_q;
  assign in_range   = ({1'b0, offset} < CSIZE_X);
  assign pc_idx     = offset[IDX_W-1:0];
  assign pc_line    = offset[IDX_W-1:LB_W];
  assign pc_byte    = offset[LB_W-1:0];
  assign pc_aligned = pc & ALIGN_MASK;
  assign rdy_acc    = rom_req_q & rom_rdy;

  always_comb begin
    state_d     = state_q;
    cbr_d       = cbr_q;
    valid_d     = valid_q;
    cnt_d       = cnt_q;
    line_d      = line_q;
    byte_d      = byte_q;
    instr_d     = instr_q;
    rom_req_d   = rom_req_q;
    rom_addr_d  = rom_addr_q;
    pend_d      = pend_q;
    pend_base_d = pend_base_q;
    mem_we      = 1'b0;
    mem_widx    = {line_q, cnt_q};

    case (state_q)
      S_IDLE: begin
        if (cache_start) begin
          cbr_d   = pc_aligned;
          valid_d = '0;
        end else if (fetch_req) begin
          if (in_range && valid_q[pc_line]) begin
            instr_d = mem_q[pc_idx];
            state_d = S_RESP;
          end else if (in_range) begin
            state_d    = S_FILL;
            cnt_d      = '0;
            line_d     = pc_line;
            byte_d     = pc_byte;
            rom_req_d  = 1'b1;
            rom_addr_d = cbr_q + (offset & ALIGN_MASK);
          end else begin
            state_d    = S_BYPASS;
            rom_req_d  = 1'b1;
            rom_addr_d = pc;
          end
        end
      end

      S_FILL: begin
        if (rdy_acc) begin
          mem_we = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == byte_q) begin
            instr_d = rom_data;
          end
          if (cnt_q == LAST_BEAT) begin
            valid_d[line_q] = 1'b1;
            rom_req_d       = 1'b0;
            state_d         = S_RESP;
          end else begin
            rom_addr_d = rom_addr_q + 1'b1;
          end
        end
      end

      S_BYPASS: begin
        if (rdy_acc) begin
          instr_d   = rom_data;
          rom_req_d = 1'b0;
          state_d   = S_RESP;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
        pend_d  = 1'b0;
        // A pulse landing in RESP is newer than any pending base.
        if (cache_start) begin
          cbr_d   = pc_aligned;
          valid_d = '0;
        end else if (pend_q) begin
          cbr_d   = pend_base_q;
          valid_d = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (cache_start && (state_q == S_FILL || state_q == S_BYPASS)) begin
      pend_d      = 1'b1;
      pend_base_d = pc_aligned;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cbr_q       <= '0;
      valid_q     <= '0;
      cnt_q       <= '0;
      line_q      <= '0;
      byte_q      <= '0;
      instr_q     <= '0;
      rom_req_q   <= 1'b0;
      rom_addr_q  <= '0;
      pend_q      <= 1'b0;
      pend_base_q <= '0;
    end else begin
      state_q     <= state_d;
      cbr_q       <= cbr_d;
      valid_q     <= valid_d;
      cnt_q       <= cnt_d;
      line_q      <= line_d;
      byte_q      <= byte_d;
      instr_q     <= instr_d;
      rom_req_q   <= rom_req_d;
      rom_addr_q  <= rom_addr_d;
      pend_q      <= pend_d;
      pend_base_q <= pend_base_d;
    end
  end

  // Storage needs no reset: the valid bits gate every read.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_widx] <= rom_data;
    end
  end

  assign instr_out   = instr_q;
  assign instr_valid = (state_q == S_RESP);
  assign busy        = (state_q != S_IDLE);
  assign rom_req     = rom_req_q;
  assign rom_addr    = rom_addr_q;
  assign cbr         = cbr_q;

endmodule

// File: tb/tb_superfx_icache_ctrl.sv
// Bench for superfx_icache_ctrl: directed steps plus randomized fetches against
// a byte-array cache model and a randomly stalling ROM responder.
module tb_superfx_icache_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] pc;
  logic        fetch_req;
  logic        cache_start;
  logic [7:0]  instr_out;
  logic        instr_valid;
  logic        busy;
  logic        rom_req;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic        rom_rdy;
  logic [15:0] cbr;

  superfx_icache_ctrl #(.LINE_BYTES(16), .NUM_LINES(32), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .pc(pc), .fetch_req(fetch_req), .cache_start(cache_start),
    .instr_out(instr_out), .instr_valid(instr_valid), .busy(busy), .rom_req(rom_req),
    .rom_addr(rom_addr), .rom_data(rom_data), .rom_rdy(rom_rdy), .cbr(cbr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          max_wait = 0;
  int          total_waits = 0;
  logic [7:0]  rom_key = 8'h00;
  logic [15:0] rom_log [$];

  logic [15:0] m_cbr = 16'h0;
  bit   [31:0] m_valid = '0;
  logic [7:0]  m_data [512];
  bit          m_pend = 1'b0;
  logic [15:0] m_pend_base = 16'h0;

  function automatic logic [7:0] rom_byte(input logic [15:0] a);
    return a[7:0] ^ rom_key;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ROM model: random wait states while rom_req is high, stray rom_rdy while low.
  int          wait_left;
  bit          stall_valid;
  logic [15:0] stall_addr;
  initial begin
    rom_rdy = 1'b0;
    rom_data = 8'h00;
    wait_left = -1;
    stall_valid = 1'b0;
    stall_addr = 16'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rom_rdy = 1'b0;
        wait_left = -1;
        stall_valid = 1'b0;
      end else if (rom_req) begin
        if (stall_valid) chk("rom_addr_stable", rom_addr, stall_addr);
        if (wait_left < 0) wait_left = int'($urandom_range(0, max_wait));
        if (wait_left == 0) begin
          rom_rdy = 1'b1;
          rom_data = rom_byte(rom_addr);
          rom_log.push_back(rom_addr);
          wait_left = -1;
          stall_valid = 1'b0;
        end else begin
          rom_rdy = 1'b0;
          rom_data = 8'($urandom);
          wait_left--;
          total_waits++;
          stall_addr = rom_addr;
          stall_valid = 1'b1;
        end
      end else begin
        rom_rdy = ($urandom_range(0, 3) == 0);
        rom_data = 8'($urandom);
        wait_left = -1;
        stall_valid = 1'b0;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_cache_start(input logic [15:0] p);
    @(negedge clk);
    pc = p;
    cache_start = 1'b1;
    @(negedge clk);
    cache_start = 1'b0;
    m_cbr = p & 16'hFFF0;
    m_valid = '0;
    chk("cbr_after_cache_start", cbr, m_cbr);
  endtask

  task automatic do_fetch(input logic [15:0] a, input bit cs_same,
                          input int cs1_at, input logic [15:0] cs1_pc,
                          input int cs2_at, input logic [15:0] cs2_pc);
    logic [15:0] off, base;
    logic [7:0]  exp_b;
    logic [15:0] exp_q [$];
    int          kind, lat, got;
    if (cs_same) begin
      m_cbr = a & 16'hFFF0;
      m_valid = '0;
    end
    off = a - m_cbr;
    exp_q.delete();
    if (off < 16'd512 && m_valid[off[8:4]]) begin
      kind = 0;
      exp_b = m_data[off[8:0]];
    end else if (off < 16'd512) begin
      kind = 1;
      base = m_cbr + (off & 16'hFFF0);
      for (int i = 0; i < 16; i++) begin
        exp_q.push_back(base + 16'(i));
        m_data[{off[8:4], 4'(i)}] = rom_byte(base + 16'(i));
      end
      m_valid[off[8:4]] = 1'b1;
      exp_b = rom_byte(a);
    end else begin
      kind = 2;
      exp_q.push_back(a);
      exp_b = rom_byte(a);
    end

    @(negedge clk);
    rom_log.delete();
    total_waits = 0;
    pc = a;
    fetch_req = 1'b1;
    cache_start = cs_same;
    got = 0;
    lat = 0;
    for (int k = 1; k <= 2000; k++) begin
      @(negedge clk);
      if (instr_valid) begin
        got = 1;
        lat = k;
        break;
      end
      cache_start = 1'b0;
      pc = a;
      if (k == cs1_at) begin
        cache_start = 1'b1;
        pc = cs1_pc;
        m_pend = 1'b1;
        m_pend_base = cs1_pc & 16'hFFF0;
      end
      if (k == cs2_at) begin
        cache_start = 1'b1;
        pc = cs2_pc;
        m_pend = 1'b1;
        m_pend_base = cs2_pc & 16'hFFF0;
      end
    end
    chk("response_seen", got, 1);
    if (got == 1) begin
      chk($sformatf("latency_k%0d_%h", kind, a), lat,
          (kind == 0 ? 1 : (kind == 1 ? 17 + total_waits : 2 + total_waits)) + (cs_same ? 1 : 0));
      chk($sformatf("instr_out_%h", a), instr_out, exp_b);
      chk("rom_req_low_in_resp", rom_req, 0);
      chk("busy_in_resp", busy, 1);
      chk("rom_read_count", rom_log.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < rom_log.size(); i++)
        chk($sformatf("rom_addr_beat%0d", i), rom_log[i], exp_q[i]);
    end
    fetch_req = 1'b0;
    cache_start = 1'b0;
    if (m_pend) begin
      m_cbr = m_pend_base;
      m_valid = '0;
      m_pend = 1'b0;
    end
    @(negedge clk);
    chk("instr_valid_one_cycle", instr_valid, 0);
    chk("idle_after_resp", busy, 0);
    chk("cbr_after_fetch", cbr, m_cbr);
  endtask

  initial begin
    logic [15:0] a;
    int seen;
    rst = 1'b1;
    pc = 16'h0;
    fetch_req = 1'b0;
    cache_start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_instr_out", instr_out, 0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rom_req", rom_req, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_cbr", cbr, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_rom_req", rom_req, 0);
    chk("post_rst_cbr", cbr, 0);

    max_wait = 0;
    do_cache_start(16'h8013);
    do_fetch(16'h8013, 0, -1, 0, -1, 0);
    do_fetch(16'h8014, 0, -1, 0, -1, 0);
    do_fetch(16'h8210, 0, -1, 0, -1, 0);
    do_fetch(16'h8210, 0, -1, 0, -1, 0);
    do_fetch(16'h820F, 0, -1, 0, -1, 0);

    max_wait = 3;
    do_cache_start(16'h9005);
    do_fetch(16'h9008, 0, 3, 16'h1234, 10, 16'h9005);
    do_fetch(16'h9008, 0, -1, 0, -1, 0);
    do_fetch(16'h900F, 0, -1, 0, -1, 0);
    do_fetch(16'h4567, 1, -1, 0, -1, 0);

    do_cache_start(16'hFF00);
    do_fetch(16'h00F0, 0, -1, 0, -1, 0);
    do_fetch(16'h00FF, 0, -1, 0, -1, 0);
    do_fetch(16'hFEFF, 0, -1, 0, -1, 0);

    max_wait = 1;
    do_cache_start(16'h9005);
    @(negedge clk);
    rom_log.delete();
    pc = 16'h9020;
    fetch_req = 1'b1;
    for (int k = 0; k < 400 && rom_log.size() < 7; k++) @(negedge clk);
    chk("reached_beat7", rom_log.size() >= 7, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_rom_req", rom_req, 0);
    chk("rst_mid_instr_valid", instr_valid, 0);
    chk("rst_mid_busy", busy, 0);
    fetch_req = 1'b0;
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      seen += int'(instr_valid);
    end
    rst = 1'b0;
    m_cbr = 16'h0;
    m_valid = '0;
    m_pend = 1'b0;
    repeat (2) begin
      @(negedge clk);
      seen += int'(instr_valid);
    end
    chk("no_resp_after_abort", seen, 0);
    chk("cbr_after_mid_rst", cbr, 0);
    do_cache_start(16'h9005);
    do_fetch(16'h9020, 0, -1, 0, -1, 0);

    for (int it = 0; it < 60; it++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0) do_cache_start(16'($urandom));
      if (r == 1) rom_key = 8'($urandom);
      max_wait = int'($urandom_range(0, 3));
      if ($urandom_range(0, 9) < 7) a = m_cbr + 16'($urandom_range(0, 600));
      else a = 16'($urandom);
      if ($urandom_range(0, 5) == 0)
        do_fetch(a, 0, int'($urandom_range(2, 6)), 16'($urandom), -1, 0);
      else
        do_fetch(a, $urandom_range(0, 9) == 0, -1, 0, -1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
